// File: rtl/pes_tlc_multi.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pes_tlc_multi
// Description : Multi-approach traffic light controller. Serves N_WAY
//               approaches round-robin, granting green only where sensor
//               demand has been latched. Green is extended while the served
//               approach keeps demanding, up to a maximum green under
//               contention. Yellow and all-red clearance follow each green.
//               All durations are in ticks of TICK_DIV clocks.
// Ports       : clk        - clock, rising edge
//               rst_n      - asynchronous active-low reset
//               sensor     - vehicle present, one bit per approach
//               light      - 3-bit lamp code per approach (RED=100,
//                            YELLOW=010, GREEN=001), approach i at [3i+2:3i]
//               active_id  - approach owning green/yellow (last owner in
//                            all-red)
//               phase      - 00 GREEN, 01 YELLOW, 10 ALL_RED
// Revision    : 1.0 - initial release
// ============================================================================
module pes_tlc_multi #(
    parameter int N_WAY       = 4,
    parameter int TICK_DIV    = 1,
    parameter int T_MIN_GREEN = 8,
    parameter int T_MAX_GREEN = 32,
    parameter int T_YELLOW    = 3,
    parameter int T_ALL_RED   = 1,
    parameter int CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_WAY-1:0]           sensor,
    output logic [3*N_WAY-1:0]         light,
    output logic [$clog2(N_WAY)-1:0]   active_id,
    output logic [1:0]                 phase
);

    localparam int c_ID_W = $clog2(N_WAY);

    // The elapsed counter is cleared on state entry, so it holds (clocks
    // spent in state - 1). Each limit is therefore one below the duration.
    localparam logic [CNT_W-1:0] c_MIN_LIM = CNT_W'(T_MIN_GREEN * TICK_DIV - 1);
    localparam logic [CNT_W-1:0] c_MAX_LIM = CNT_W'(T_MAX_GREEN * TICK_DIV - 1);
    localparam logic [CNT_W-1:0] c_YEL_LIM = CNT_W'(T_YELLOW * TICK_DIV - 1);
    localparam logic [CNT_W-1:0] c_AR_LIM  = CNT_W'(T_ALL_RED * TICK_DIV - 1);

    localparam logic [2:0] c_LAMP_RED = 3'b100;
    localparam logic [2:0] c_LAMP_YEL = 3'b010;
    localparam logic [2:0] c_LAMP_GRN = 3'b001;

    localparam logic [3*N_WAY-1:0] c_RESET_LIGHT = {{(N_WAY-1){c_LAMP_RED}}, c_LAMP_GRN};
    localparam logic [N_WAY-1:0]   c_ONE         = {{(N_WAY-1){1'b0}}, 1'b1};

    // Encoding doubles as the phase output code.
    typedef enum logic [1:0] {
        ST_GREEN   = 2'b00,
        ST_YELLOW  = 2'b01,
        ST_ALL_RED = 2'b10
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_ID_W-1:0]     r_cur;
    logic [c_ID_W-1:0]     w_cur_nxt;
    logic [c_ID_W-1:0]     w_rr_pick;
    logic [c_ID_W-1:0]     w_rr_idx;
    logic [CNT_W-1:0]      r_elapsed;
    logic [N_WAY-1:0]      r_req;
    logic [N_WAY-1:0]      w_req_nxt;
    logic [N_WAY-1:0]      w_cur_mask;
    logic [N_WAY-1:0]      w_grant_mask;
    logic [N_WAY-1:0]      w_sense_mask;
    logic                  w_other;
    logic [2:0]            w_cur_lamp;
    logic [3*N_WAY-1:0]    w_light_nxt;
    logic [3*N_WAY-1:0]    r_light;
    logic [c_ID_W-1:0]     r_active_id;
    logic [1:0]            r_phase;

    assign w_cur_mask = c_ONE << r_cur;
    assign w_other    = |(r_req & ~w_cur_mask);

    // Round-robin search for the next approach with latched demand.
    // Scanning from the farthest offset down to cur+1 lets the nearest
    // candidate overwrite the others, so no found flag is needed. When
    // nothing is pending the current approach is kept.
    always_comb begin
        w_rr_pick = r_cur;
        w_rr_idx  = '0;
        for (int k = N_WAY - 1; k >= 1; k--) begin
            w_rr_idx = c_ID_W'((int'(r_cur) + k) % N_WAY);
            if (r_req[w_rr_idx]) begin
                w_rr_pick = w_rr_idx;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        case (r_state)
            ST_GREEN: begin
                // Gap-out once minimum green is served and the holder has
                // stopped demanding; max-out regardless of the holder.
                if (w_other && (((r_elapsed >= c_MIN_LIM) && !sensor[r_cur]) ||
                                (r_elapsed >= c_MAX_LIM))) begin
                    w_state_nxt = ST_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (r_elapsed >= c_YEL_LIM) begin
                    w_state_nxt = ST_ALL_RED;
                end
            end
            ST_ALL_RED: begin
                if (r_elapsed >= c_AR_LIM) begin
                    w_state_nxt = ST_GREEN;
                    w_cur_nxt   = w_rr_pick;
                end
            end
            default: begin
                w_state_nxt = ST_GREEN;
            end
        endcase
    end

    // Demand latch: the green holder does not latch its own sensor, and
    // an approach entering green has its request cleared, which wins over
    // a simultaneous set.
    always_comb begin
        w_sense_mask = sensor & ~((r_state == ST_GREEN) ? w_cur_mask : '0);
        w_grant_mask = ((w_state_nxt == ST_GREEN) && (r_state != ST_GREEN)) ?
                       (c_ONE << w_cur_nxt) : '0;
        w_req_nxt    = (r_req | w_sense_mask) & ~w_grant_mask;
    end

    // Lamp decode from the next state so the outputs move with the state.
    always_comb begin
        case (w_state_nxt)
            ST_GREEN:  w_cur_lamp = c_LAMP_GRN;
            ST_YELLOW: w_cur_lamp = c_LAMP_YEL;
            default:   w_cur_lamp = c_LAMP_RED;
        endcase
    end

    generate
        for (genvar i = 0; i < N_WAY; i++) begin : g_lamp
            assign w_light_nxt[3*i +: 3] = (w_cur_nxt == c_ID_W'(i)) ? w_cur_lamp : c_LAMP_RED;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_GREEN;
            r_cur       <= '0;
            r_req       <= '0;
            r_elapsed   <= '0;
            r_light     <= c_RESET_LIGHT;
            r_active_id <= '0;
            r_phase     <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_req   <= w_req_nxt;
            if (w_state_nxt != r_state) begin
                r_elapsed <= '0;
            end else if (r_elapsed != '1) begin
                r_elapsed <= r_elapsed + CNT_W'(1);
            end
            r_light     <= w_light_nxt;
            r_active_id <= w_cur_nxt;
            r_phase     <= w_state_nxt;
        end
    end

    assign light     = r_light;
    assign active_id = r_active_id;
    assign phase     = r_phase;

endmodule
`default_nettype wire
